assoc_seq_ctrl: RTL and testbench

Sequencer for the sequential associative-memory stage: walks every class hypervector chunk by chunk, drives the enable and chunk-index inputs of the 13-bit class-score accumulator, then compares each finished class score to find the best match (argmax). Sits between the query/class-memory popcount datapath, which produces one 10-bit chunk sum per handshake, and the classifier output register.

---
 rtl/assoc_seq_ctrl_pkg.sv | 16 +
 rtl/assoc_seq_ctrl_if.sv | 34 +++
 rtl/assoc_seq_ctrl_argmax.sv | 33 +++
 rtl/assoc_seq_ctrl.sv | 102 ++++++++++
 tb/tb_assoc_seq_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/assoc_seq_ctrl_pkg.sv
// Shared types and widths for the sequential associative-memory stage.
// Also used by the class-score accumulator and popcount blocks.
package assoc_seq_ctrl_pkg;

   localparam int ACC_W   = 13;
   localparam int SUM_W   = 10;
   localparam int STATE_W = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACCUM   = 2'd1,
      S_COMPARE = 2'd2,
      S_DONE    = 2'd3
   } fsm_t;

endpackage

// File: rtl/assoc_seq_ctrl_if.sv
// Link between the sequencer and the popcount/accumulator datapath.
// master = sequencer, slave = datapath.
interface assoc_seq_ctrl_if
   import assoc_seq_ctrl_pkg::*;
#(
   parameter int CW = 4
) ();

   logic               sum_valid;
   logic [ACC_W-1:0]   stored_score;
   logic               acc_en;
   logic [STATE_W-1:0] acc_state;
   logic [CW-1:0]      class_idx;
   logic [STATE_W-1:0] chunk_idx;

   modport master (
      input  sum_valid,
      input  stored_score,
      output acc_en,
      output acc_state,
      output class_idx,
      output chunk_idx
   );

   modport slave (
      output sum_valid,
      output stored_score,
      input  acc_en,
      input  acc_state,
      input  class_idx,
      input  chunk_idx
   );

endinterface

// File: rtl/assoc_seq_ctrl_argmax.sv
// Best-match register pair with strict greater-than update.
// Ties keep the earlier (lower) class index.
module assoc_argmax
   import assoc_seq_ctrl_pkg::*;
#(
   parameter int CW = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmp_en,
   input  logic             first,
   input  logic [CW-1:0]    class_idx,
   input  logic [ACC_W-1:0] score,
   output logic [CW-1:0]    best_class,
   output logic [ACC_W-1:0] best_score
);

   logic load;

   // class 0 always loads so a new query never inherits the old best
   assign load = cmp_en && (first || (score > best_score));

   always_ff @(posedge clk) begin
      if (rst) begin
         best_class <= '0;
         best_score <= '0;
      end else if (load) begin
         best_class <= class_idx;
         best_score <= score;
      end
   end

endmodule

// File: rtl/assoc_seq_ctrl.sv
// Sequencer for the associative-memory stage: walks class/chunk indices,
// drives the score accumulator, and tracks the argmax class.
module assoc_seq_ctrl
   import assoc_seq_ctrl_pkg::*;
#(
   parameter int NUM_CLASSES = 10,
   parameter int CHUNKS      = 8,
   parameter int CW          = $clog2(NUM_CLASSES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   assoc_seq_ctrl_if.master dp,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    best_class,
   output logic [ACC_W-1:0] best_score
);

   localparam logic [CW-1:0]      LAST_CLS = CW'(NUM_CLASSES - 1);
   localparam logic [STATE_W-1:0] LAST_CHK = STATE_W'(CHUNKS - 1);

   fsm_t               state_q;
   fsm_t               state_d;
   logic [CW-1:0]      cls_q;
   logic [STATE_W-1:0] chunk_q;
   logic               last_chunk;
   logic               last_class;
   logic               cmp_en;

   assign last_chunk = (chunk_q == LAST_CHK);
   assign last_class = (cls_q == LAST_CLS);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_ACCUM;
         S_ACCUM:   if (dp.sum_valid && last_chunk)
                       state_d = S_COMPARE;
         S_COMPARE: state_d = last_class ? S_DONE : S_ACCUM;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dp.acc_en = 1'b0;
      cmp_en    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state_q)
         S_IDLE:    busy      = 1'b0;
         S_ACCUM:   dp.acc_en = dp.sum_valid;
         S_COMPARE: cmp_en    = 1'b1;
         S_DONE:    done      = 1'b1;
         default:   busy      = 1'b0;
      endcase
   end

   // chunk 0 carries acc_state 0, which clears the accumulator per class
   assign dp.acc_state = chunk_q;
   assign dp.chunk_idx = chunk_q;
   assign dp.class_idx = cls_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cls_q   <= '0;
         chunk_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               cls_q   <= '0;
               chunk_q <= '0;
            end
            S_ACCUM: if (dp.sum_valid && !last_chunk)
               chunk_q <= chunk_q + 4'd1;
            S_COMPARE: if (!last_class) begin
               cls_q   <= cls_q + 1'b1;
               chunk_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assoc_argmax #(.CW(CW)) u_argmax (
      .clk        (clk),
      .rst        (rst),
      .cmp_en     (cmp_en),
      .first      (cls_q == '0),
      .class_idx  (cls_q),
      .score      (dp.stored_score),
      .best_class (best_class),
      .best_score (best_score)
   );

endmodule

// File: tb/tb_assoc_seq_ctrl.sv
// Directed bench for assoc_seq_ctrl with a behavioural class-score
// accumulator fed from a per-class chunk-sum table.
module tb_assoc_seq_ctrl;

   localparam int P_PH_IDLE = 0;
   localparam int P_PH_ACC  = 1;
   localparam int P_PH_CMP  = 2;
   localparam int P_PH_DONE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sum_valid;
   logic        busy;
   logic        done;
   logic [3:0]  best_class;
   logic [12:0] best_score;
   logic [12:0] acc;
   logic [9:0]  csum [16];

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assoc_seq_ctrl_if #(.CW(4)) dp ();

   assign dp.sum_valid    = sum_valid;
   assign dp.stored_score = acc;

   assoc_seq_ctrl #(
      .NUM_CLASSES (10),
      .CHUNKS      (8),
      .CW          (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dp         (dp),
      .busy       (busy),
      .done       (done),
      .best_class (best_class),
      .best_score (best_score)
   );

   // external class-score accumulator
   always @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (dp.acc_en)
         acc <= (dp.acc_state == 4'd0) ? 13'(csum[dp.class_idx])
                : acc + 13'(csum[dp.class_idx]);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic fill(input int base);
      for (int i = 0; i < 16; i++) csum[i] = 10'(base);
   endtask

   task automatic run_q(input bit stall, input bit hold, input bit abort,
                        output int dcyc, output int nst, output int mism);
      int ph;
      int cls;
      int ch;
      int cyc;
      bit fin;
      bit exp_en;
      ph = P_PH_IDLE; cls = 0; ch = 0; cyc = 0; fin = 0;
      dcyc = -1; nst = 0; mism = 0;
      @(negedge clk);
      start = 1'b1;
      while (!fin && cyc < 400) begin
         if (cyc > 0 && !hold) start = 1'b0;
         sum_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (abort && ph == P_PH_ACC && cls == 4 && ch == 5) begin
            rst = 1'b1;
            break;
         end
         #1;
         exp_en = (ph == P_PH_ACC) && sum_valid;
         if (dp.acc_en !== exp_en) mism++;
         if (exp_en && (dp.acc_state !== 4'(ch) ||
                        dp.class_idx !== 4'(cls))) mism++;
         if (busy !== (ph != P_PH_IDLE)) mism++;
         if (done !== (ph == P_PH_DONE)) mism++;
         if (done === 1'b1) dcyc = cyc;
         if (ph == P_PH_ACC && !sum_valid) nst++;
         case (ph)
            P_PH_IDLE: if (start) begin
               ph = P_PH_ACC; cls = 0; ch = 0;
            end
            P_PH_ACC: if (sum_valid) begin
               if (ch == 7) ph = P_PH_CMP;
               else ch++;
            end
            P_PH_CMP: if (cls == 9) ph = P_PH_DONE;
               else begin
                  cls++; ch = 0; ph = P_PH_ACC;
               end
            default: begin
               ph = P_PH_IDLE; fin = 1;
            end
         endcase
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 400) chk("timeout", 32'(cyc), 0);
   endtask

   int dcyc;
   int nst;
   int mism;
   int ndone;

   initial begin
      rst = 1'b1; start = 1'b1; sum_valid = 1'b0;
      fill(0);
      repeat (3) @(negedge clk);
      chk("rst_acc_en", 32'(dp.acc_en), 0);
      chk("rst_acc_state", 32'(dp.acc_state), 0);
      chk("rst_class_idx", 32'(dp.class_idx), 0);
      chk("rst_chunk_idx", 32'(dp.chunk_idx), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_best_class", 32'(best_class), 0);
      chk("rst_best_score", 32'(best_score), 0);
      rst = 1'b0; start = 1'b0;

      fill(100); csum[3] = 10'd120;
      run_q(0, 0, 0, dcyc, nst, mism);
      chk("q1_seq", 32'(mism), 0);
      chk("q1_latency", 32'(dcyc), 91);
      chk("q1_class", 32'(best_class), 3);
      chk("q1_score", 32'(best_score), 960);

      fill(50); csum[2] = 10'd100; csum[5] = 10'd100;
      run_q(0, 0, 0, dcyc, nst, mism);
      chk("tie_seq", 32'(mism), 0);
      chk("tie_class", 32'(best_class), 2);
      chk("tie_score", 32'(best_score), 800);

      fill(0); csum[9] = 10'd1023;
      run_q(0, 0, 0, dcyc, nst, mism);
      chk("max_seq", 32'(mism), 0);
      chk("max_class", 32'(best_class), 9);
      chk("max_score", 32'(best_score), 8184);

      fill(100); csum[3] = 10'd120;
      run_q(1, 0, 0, dcyc, nst, mism);
      chk("stall_seq", 32'(mism), 0);
      chk("stall_latency", 32'(dcyc), 32'(91 + nst));
      chk("stall_class", 32'(best_class), 3);
      chk("stall_score", 32'(best_score), 960);

      fill(10); csum[7] = 10'd200;
      run_q(0, 0, 1, dcyc, nst, mism);
      chk("abort_seq", 32'(mism), 0);
      @(negedge clk);
      #1;
      chk("abort_acc_en", 32'(dp.acc_en), 0);
      chk("abort_class_idx", 32'(dp.class_idx), 0);
      chk("abort_chunk_idx", 32'(dp.chunk_idx), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_best_score", 32'(best_score), 0);
      rst = 1'b0; start = 1'b0;
      ndone = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      chk("abort_quiet", 32'(ndone), 0);
      run_q(0, 0, 0, dcyc, nst, mism);
      chk("q2_seq", 32'(mism), 0);
      chk("q2_latency", 32'(dcyc), 91);
      chk("q2_class", 32'(best_class), 7);
      chk("q2_score", 32'(best_score), 1600);

      fill(80); csum[0] = 10'd90;
      run_q(0, 1, 0, dcyc, nst, mism);
      chk("hold_seq", 32'(mism), 0);
      chk("hold_latency", 32'(dcyc), 91);
      chk("hold_class", 32'(best_class), 0);
      chk("hold_score", 32'(best_score), 720);
      chk("hold_idle_gap", 32'(busy), 0);
      @(negedge clk);
      chk("hold_restart", 32'(busy), 1);
      start = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
